// File: rtl/bw_io_bs_pkg.sv
// Shared definitions for the boundary-scan data register: counter sizing helper.
package bw_io_bs_pkg;

    localparam int BS_MIN_CNT_W = 1;

    // Bits needed to count 0..width shifts, never less than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width + 1);
        if (w < BS_MIN_CNT_W) begin
            w = BS_MIN_CNT_W;
        end
        return w;
    endfunction

endpackage

// File: rtl/bw_io_bs_cell.sv
// One boundary-scan cell: capture/shift flop, update (hold) flop and the pad-side
// functional/test output mux.
module bw_io_bs_cell #(
    parameter logic RST_UPD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic mode,
    input  logic scan_in,
    input  logic pin_in,
    input  logic core_in,
    output logic scan_out,
    output logic pin_out,
    output logic upd_q
);

    logic sr_q;
    logic sr_d;
    logic upd_d;

    always_comb begin
        sr_d = sr_q;
        if (capture_en) begin
            sr_d = pin_in;
        end else if (shift_en) begin
            sr_d = scan_in;
        end
    end

    // Update samples the shift flop as held before this edge, so a same-cycle
    // capture or shift never leaks into the update stage.
    assign upd_d = update_en ? sr_q : upd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= 1'b0;
            upd_q <= RST_UPD;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
        end
    end

    assign scan_out = sr_q;
    assign pin_out  = mode ? upd_q : core_in;

endmodule

// File: rtl/bw_io_bs_dreg.sv
// WIDTH-bit boundary-scan data register: chain of bw_io_bs_cell plus shift counter
// and update-seen flag. All state on one clock with synchronous active-high reset.
module bw_io_bs_dreg
    import bw_io_bs_pkg::*;
#(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] UPD_RST = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture_dr,
    input  logic                          shift_dr,
    input  logic                          update_dr,
    input  logic                          mode,
    input  logic                          scan_in,
    input  logic [WIDTH-1:0]              pin_in,
    input  logic [WIDTH-1:0]              core_in,
    output logic                          scan_out,
    output logic [WIDTH-1:0]              pin_out,
    output logic [WIDTH-1:0]              upd_q,
    output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
    output logic                          shift_full,
    output logic                          upd_valid
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    // No handshake: capture_dr/shift_dr/update_dr are single-cycle qualifiers
    // sampled on every rising edge; a held enable acts on every cycle.
    logic             capture_en;
    logic             shift_en;
    logic [WIDTH-1:0] sr_chain;
    logic [WIDTH-1:0] chain_in;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;
    logic             valid_d;

    assign capture_en = capture_dr;
    assign shift_en   = shift_dr & ~capture_dr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_head
            assign chain_in[i] = scan_in;
        end else begin : g_link
            assign chain_in[i] = sr_chain[i+1];
        end

        bw_io_bs_cell #(
            .RST_UPD (UPD_RST[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .capture_en (capture_en),
            .shift_en   (shift_en),
            .update_en  (update_dr),
            .mode       (mode),
            .scan_in    (chain_in[i]),
            .pin_in     (pin_in[i]),
            .core_in    (core_in[i]),
            .scan_out   (sr_chain[i]),
            .pin_out    (pin_out[i]),
            .upd_q      (upd_q[i])
        );
    end

    // Counter saturates at WIDTH so long shift runs never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (capture_en) begin
            cnt_d = '0;
        end else if (shift_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign valid_d = valid_q | update_dr;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign scan_out   = sr_chain[0];
    assign shift_cnt  = cnt_q;
    assign shift_full = (cnt_q == CNT_MAX);
    assign upd_valid  = valid_q;

endmodule

// File: tb/tb_bw_io_bs_dreg.sv
// Self-checking bench for bw_io_bs_dreg (WIDTH=3, non-zero UPD_RST): directed
// vector table, reset corner sequence, then randomized run against a bit-level model.
module tb_bw_io_bs_dreg;

    localparam int         W      = 3;
    localparam logic [2:0] U_RST  = 3'b010;

    logic       clk;
    logic       rst;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       mode;
    logic       scan_in;
    logic [2:0] pin_in;
    logic [2:0] core_in;
    logic       scan_out;
    logic [2:0] pin_out;
    logic [2:0] upd_q;
    logic [1:0] shift_cnt;
    logic       shift_full;
    logic       upd_valid;

    int n_cmp;
    int n_err;

    // Reference state: the shift stage is an integer, shifted arithmetically.
    int unsigned sr_m;
    int unsigned upd_m;
    int unsigned cnt_m;
    bit          valid_m;

    typedef struct {
        logic       cap;
        logic       sh;
        logic       upd;
        logic       md;
        logic       si;
        logic [2:0] pin;
        logic [2:0] core;
        logic       e_so;
        logic [2:0] e_upd;
        logic [2:0] e_po;
        logic [1:0] e_cnt;
        logic       e_full;
        logic       e_valid;
    } vec_t;

    vec_t tbl[16];

    bw_io_bs_dreg #(
        .WIDTH   (W),
        .UPD_RST (U_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .mode       (mode),
        .scan_in    (scan_in),
        .pin_in     (pin_in),
        .core_in    (core_in),
        .scan_out   (scan_out),
        .pin_out    (pin_out),
        .upd_q      (upd_q),
        .shift_cnt  (shift_cnt),
        .shift_full (shift_full),
        .upd_valid  (upd_valid)
    );

    // Clock and reset-time defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int unsigned old_sr;
        old_sr = sr_m;
        if (rst) begin
            sr_m    = 0;
            upd_m   = U_RST;
            cnt_m   = 0;
            valid_m = 1'b0;
        end else begin
            if (capture_dr) begin
                sr_m  = pin_in;
                cnt_m = 0;
            end else if (shift_dr) begin
                sr_m  = (sr_m >> 1) | (int'(scan_in) << (W - 1));
                cnt_m = (cnt_m + 1 > W) ? W : cnt_m + 1;
            end
            if (update_dr) begin
                upd_m   = old_sr;
                valid_m = 1'b1;
            end
        end
    endfunction

    // Driver: apply inputs, take one edge, advance the model, settle before checks.
    task automatic step(input logic r, input logic cap, input logic sh, input logic upd,
                        input logic md, input logic si, input logic [2:0] pin,
                        input logic [2:0] core);
        rst        = r;
        capture_dr = cap;
        shift_dr   = sh;
        update_dr  = upd;
        mode       = md;
        scan_in    = si;
        pin_in     = pin;
        core_in    = core;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [2:0] po_m;
        po_m = mode ? 3'(upd_m) : core_in;
        chk({tag, ".scan_out"},   8'(scan_out),   8'(sr_m & 1));
        chk({tag, ".upd_q"},      8'(upd_q),      8'(upd_m));
        chk({tag, ".pin_out"},    8'(pin_out),    8'(po_m));
        chk({tag, ".shift_cnt"},  8'(shift_cnt),  8'(cnt_m));
        chk({tag, ".shift_full"}, 8'(shift_full), 8'(cnt_m == W));
        chk({tag, ".upd_valid"},  8'(upd_valid),  8'(valid_m));
    endtask

    task automatic check_exp(input string tag, input logic so, input logic [2:0] up,
                             input logic [2:0] po, input logic [1:0] cnt,
                             input logic full, input logic vld);
        chk({tag, ".scan_out"},   8'(scan_out),   8'(so));
        chk({tag, ".upd_q"},      8'(upd_q),      8'(up));
        chk({tag, ".pin_out"},    8'(pin_out),    8'(po));
        chk({tag, ".shift_cnt"},  8'(shift_cnt),  8'(cnt));
        chk({tag, ".shift_full"}, 8'(shift_full), 8'(full));
        chk({tag, ".upd_valid"},  8'(upd_valid),  8'(vld));
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        sr_m    = 0;
        upd_m   = 0;
        cnt_m   = 0;
        valid_m = 1'b0;
        rst = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        mode = 1'b0; scan_in = 1'b0; pin_in = '0; core_in = '0;

        //                cap  sh   upd  md   si   pin     core    so   upd     po      cnt  full vld
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b110, 1'b1, 3'b010, 3'b110, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b110, 1'b0, 3'b010, 3'b110, 2'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b110, 1'b1, 3'b010, 3'b110, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b110, 1'b1, 3'b010, 3'b110, 2'd3, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b110, 1'b1, 3'b001, 3'b001, 2'd3, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 3'b001, 3'b100, 2'd3, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b100, 1'b0, 3'b001, 3'b100, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b100, 1'b1, 3'b110, 3'b110, 2'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b1, 3'b111, 3'b111, 2'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b011, 1'b0, 3'b111, 3'b011, 2'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 3'b111, 3'b011, 2'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 3'b111, 3'b011, 2'd2, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 3'b111, 3'b011, 2'd3, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 3'b111, 3'b011, 2'd3, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 3'b111, 3'b011, 2'd3, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 3'b000, 3'b000, 2'd3, 1'b1, 1'b1};

        // Reset with every enable high must still land on reset values.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 3'b101);
        check_exp("rst_all_en", 1'b0, U_RST, 3'b101, 2'd0, 1'b0, 1'b0);
        mode = 1'b1;
        #1;
        chk("rst_mode1.pin_out", 8'(pin_out), 8'(U_RST));

        for (int k = 0; k < 16; k++) begin
            step(1'b0, tbl[k].cap, tbl[k].sh, tbl[k].upd, tbl[k].md, tbl[k].si,
                 tbl[k].pin, tbl[k].core);
            check_exp($sformatf("vec%0d", k), tbl[k].e_so, tbl[k].e_upd, tbl[k].e_po,
                      tbl[k].e_cnt, tbl[k].e_full, tbl[k].e_valid);
            check_model($sformatf("vec%0d_model", k));
        end

        // Reset lands two shifts into a fresh capture, then a clean sequence follows.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        check_exp("mid_shift", 1'b1, 3'b000, 3'b001, 2'd2, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b001);
        check_exp("mid_rst", 1'b0, U_RST, U_RST, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 3'b001);
        check_exp("post_cap", 1'b0, U_RST, 3'b001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        check_exp("post_shift3", 1'b1, U_RST, 3'b001, 2'd3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b001);
        check_exp("post_upd", 1'b1, 3'b011, 3'b011, 2'd3, 1'b1, 1'b1);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
